ifft_8point_seq: RTL and testbench

Sequential 8-point, 16-bit radix-2 inverse FFT engine: the reconstruction end of the spectrum path that our combinational 8-point forward FFT feeds. It accepts one complex bin per cycle over a valid/ready stream, runs all 12 butterflies through a single shared butterfly unit, and streams out 8 complex time-domain samples in natural order. The 1/N normalisation is built in.

---
 rtl/ifft_8point_seq_if.sv | 25 ++
 rtl/ifft_8point_seq.sv | 182 ++++++++++++++++++
 tb/tb_ifft_8point_seq.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifft_8point_seq_if.sv
// Stream bundle for the 8-point inverse FFT: bins in, samples out.
// Ports: in_valid/in_ready/in_re/in_im, out_valid/out_ready/out_re/out_im/out_last.
interface ifft_8point_seq_if #(
  parameter int WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_re;
  logic signed [WIDTH-1:0] in_im;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_re;
  logic signed [WIDTH-1:0] out_im;
  logic                    out_last;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last
  );
endinterface

// File: rtl/ifft_8point_seq.sv
// Sequential 8-point radix-2 DIT inverse FFT, one shared butterfly, 1/8 scaled.
// Ports: clk, rst_n (async low), bus (slave: bins in k order, samples out n order).
module ifft_8point_seq #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  ifft_8point_seq_if.slave bus
);

  localparam int W = WIDTH;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    COMP   = 2'd1,
    UNLOAD = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [2:0] n_q, n_d;
  logic [3:0] cnt_q, cnt_d;
  logic live_q;

  logic signed [W-1:0] re_q [8];
  logic signed [W-1:0] im_q [8];

  logic in_hs, out_hs;
  logic [2:0] ia, ib;
  logic [1:0] m;

  logic signed [W-1:0] ar, ai, br, bi;
  logic signed [W:0]   sd, ss, cd, cs, tr, ti;
  logic [W+8:0]        pd, ps;
  logic [W+1:0]        sa_r, sa_i, sb_r, sb_i;

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  // in_ready stays low until the first edge after reset release
  assign bus.in_ready  = live_q && (state_q == LOAD);
  assign bus.out_valid = (state_q == UNLOAD);
  assign bus.out_last  = (state_q == UNLOAD) && (n_q == 3'd7);
  assign bus.out_re    = (state_q == UNLOAD) ? re_q[n_q] : '0;
  assign bus.out_im    = (state_q == UNLOAD) ? im_q[n_q] : '0;

  assign in_hs  = bus.in_valid && bus.in_ready;
  assign out_hs = bus.out_ready && (state_q == UNLOAD);

  // cnt[3:2] = stage (span 1,2,4), cnt[1:0] = butterfly in stage
  always_comb begin
    ia = '0;
    ib = '0;
    m  = '0;
    case (cnt_q[3:2])
      2'd0: begin
        ia = {cnt_q[1:0], 1'b0};
        ib = {cnt_q[1:0], 1'b1};
      end
      2'd1: begin
        ia = {cnt_q[1], 1'b0, cnt_q[0]};
        ib = {cnt_q[1], 1'b1, cnt_q[0]};
        m  = {cnt_q[0], 1'b0};
      end
      2'd2: begin
        ia = {1'b0, cnt_q[1:0]};
        ib = {1'b1, cnt_q[1:0]};
        m  = cnt_q[1:0];
      end
      default: ;
    endcase
  end

  assign ar = re_q[ia];
  assign ai = im_q[ia];
  assign br = re_q[ib];
  assign bi = im_q[ib];

  assign sd = {br[W-1], br} - {bi[W-1], bi};
  assign ss = {br[W-1], br} + {bi[W-1], bi};

  // c*s = (s*181) >>> 8; low bits of the unsigned product equal the signed one
  assign pd = {{8{sd[W]}}, sd} * (W+9)'(181);
  assign ps = {{8{ss[W]}}, ss} * (W+9)'(181);
  assign cd = pd[W+8:8];
  assign cs = ps[W+8:8];

  always_comb begin
    tr = {br[W-1], br};
    ti = {bi[W-1], bi};
    unique case (m)
      2'd0: ;
      2'd1: begin
        tr = cd;
        ti = cs;
      end
      2'd2: begin
        tr = -{bi[W-1], bi};
        ti = {br[W-1], br};
      end
      2'd3: begin
        tr = -cs;
        ti = cd;
      end
    endcase
  end

  assign sa_r = {ar[W-1], ar[W-1], ar} + {tr[W], tr};
  assign sa_i = {ai[W-1], ai[W-1], ai} + {ti[W], ti};
  assign sb_r = {ar[W-1], ar[W-1], ar} - {tr[W], tr};
  assign sb_i = {ai[W-1], ai[W-1], ai} - {ti[W], ti};

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOAD: begin
        if (in_hs) begin
          k_d = k_q + 3'd1;
          if (k_q == 3'd7) begin
            state_d = COMP;
            cnt_d   = '0;
          end
        end
      end
      COMP: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd11) begin
          state_d = UNLOAD;
          n_d     = '0;
        end
      end
      UNLOAD: begin
        if (out_hs) begin
          n_d = n_q + 3'd1;
          if (n_q == 3'd7) begin
            state_d = LOAD;
            k_d     = '0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      k_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (in_hs) begin
      re_q[bitrev3(k_q)] <= bus.in_re;
      im_q[bitrev3(k_q)] <= bus.in_im;
    end else if (state_q == COMP) begin
      re_q[ia] <= sa_r[W:1];
      im_q[ia] <= sa_i[W:1];
      re_q[ib] <= sb_r[W:1];
      im_q[ib] <= sb_i[W:1];
    end
  end

endmodule

// File: tb/tb_ifft_8point_seq.sv
// Bench for ifft_8point_seq: directed table, random bins vs model,
// backpressure, async reset aborts and back-to-back frame period.
module tb_ifft_8point_seq;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ifft_8point_seq_if #(.WIDTH(W)) bus ();

  ifft_8point_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int xr[8];
    int xi[8];
    int yr[8];
    int yi[8];
  } vec_t;

  vec_t vecs[4];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int cur_xr[8], cur_xi[8], exp_r[8], exp_i[8];
  int first_hs, last_hs;
  int fs[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, req);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_in_ready"}, int'(bus.in_ready), 0);
    chk({nm, "_out_valid"}, int'(bus.out_valid), 0);
    chk({nm, "_out_last"}, int'(bus.out_last), 0);
    chk({nm, "_out_re"}, int'(bus.out_re), 0);
    chk({nm, "_out_im"}, int'(bus.out_im), 0);
  endtask

  function automatic int cm(input int v);
    return (v * 181) >>> 8;
  endfunction

  function automatic int wrap(input int v);
    return int'(shortint'(v));
  endfunction

  // reference: scaled DIT inverse FFT on bit-reversed buffer
  function automatic void model();
    int r[8], i[8];
    for (int k = 0; k < 8; k++) begin
      int br = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
      r[br] = cur_xr[k];
      i[br] = cur_xi[k];
    end
    for (int s = 0; s < 3; s++) begin
      int sp = 1 << s;
      for (int a = 0; a < 8; a++) begin
        if ((a & sp) == 0) begin
          int b = a + sp;
          int mm = (a % sp) * 4 / sp;
          int tr, ti, ar, ai;
          case (mm)
            0: begin tr = r[b]; ti = i[b]; end
            1: begin tr = cm(r[b] - i[b]); ti = cm(r[b] + i[b]); end
            2: begin tr = -i[b]; ti = r[b]; end
            default: begin tr = -cm(r[b] + i[b]); ti = cm(r[b] - i[b]); end
          endcase
          ar = r[a];
          ai = i[a];
          r[a] = wrap((ar + tr) >>> 1);
          i[a] = wrap((ai + ti) >>> 1);
          r[b] = wrap((ar - tr) >>> 1);
          i[b] = wrap((ai - ti) >>> 1);
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      exp_r[k] = r[k];
      exp_i[k] = i[k];
    end
  endfunction

  task automatic gen_random();
    for (int k = 0; k < 8; k++) begin
      cur_xr[k] = int'($urandom_range(0, 32766)) - 16383;
      cur_xi[k] = int'($urandom_range(0, 32766)) - 16383;
    end
    model();
  endtask

  task automatic use_vec(input int v);
    for (int k = 0; k < 8; k++) begin
      cur_xr[k] = vecs[v].xr[k];
      cur_xi[k] = vecs[v].xi[k];
      exp_r[k]  = vecs[v].yr[k];
      exp_i[k]  = vecs[v].yi[k];
    end
  endtask

  task automatic load(input bit gappy);
    int k = 0;
    int guard = 0;
    bit hs;
    while (k < 8 && guard < 200) begin
      bus.in_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_re = bus.in_valid ? W'(cur_xr[k]) : W'($urandom);
      bus.in_im = bus.in_valid ? W'(cur_xi[k]) : W'($urandom);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        if (k == 0) first_hs = cyc;
        if (k == 7) last_hs = cyc;
        k++;
      end
      guard++;
    end
    bus.in_valid = 1'b0;
    if (k < 8) begin
      n_chk++;
      $display("FAIL load_timeout: got %0d bins accepted, required 8", k);
    end
  endtask

  task automatic collect(input bit rnd, input int stop_n);
    int n = 0;
    int guard = 0;
    bit seen = 0;
    bit stall = 0;
    bit rdy;
    logic [2*W+1:0] held, snap;
    while (n < 8 && guard < 300) begin
      if (n == stop_n) begin
        bus.out_ready = 1'b0;
        return;
      end
      snap = {bus.out_valid, bus.out_last, bus.out_re, bus.out_im};
      if (bus.out_valid && !seen) begin
        seen = 1;
        chk("latency", cyc - last_hs, 12);
      end
      chk("in_ready_low", int'(bus.in_ready), 0);
      if (stall) chk("hold_stable", int'(snap == held), 1);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rdy;
      stall = 0;
      if (bus.out_valid && rdy) begin
        chk($sformatf("re[%0d]", n), int'(bus.out_re), exp_r[n]);
        chk($sformatf("im[%0d]", n), int'(bus.out_im), exp_i[n]);
        chk($sformatf("last[%0d]", n), int'(bus.out_last), (n == 7) ? 1 : 0);
        n++;
      end else if (bus.out_valid) begin
        stall = 1;
        held = snap;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    if (n < 8) begin
      n_chk++;
      $display("FAIL unload_timeout: got %0d samples, required 8", n);
    end else begin
      chk("post_out_valid", int'(bus.out_valid), 0);
      chk("post_in_ready", int'(bus.in_ready), 1);
    end
  endtask

  task automatic pulse_reset(input string nm);
    #2 rst_n = 1'b0;
    #1 chk_reset(nm);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk({nm, "_ready_before_edge"}, int'(bus.in_ready), 0);
    @(posedge clk);
    #1 chk({nm, "_ready_after_edge"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0].xr = '{8000, 0, 0, 0, 0, 0, 0, 0};
    vecs[0].xi = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[0].yr = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    vecs[0].yi = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].xr = '{800, 800, 800, 800, 800, 800, 800, 800};
    vecs[1].xi = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].yr = '{800, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].yi = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2].xr = '{0, 8000, 0, 0, 0, 0, 0, 0};
    vecs[2].xi = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2].yr = '{1000, 707, 0, -707, -1000, -707, 0, 707};
    vecs[2].yi = '{0, 707, 1000, 707, 0, -707, -1000, -707};
    vecs[3].xr = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3].xi = '{0, 0, 8000, 0, 0, 0, 0, 0};
    vecs[3].yr = '{0, -1000, 0, 1000, 0, -1000, 0, 1000};
    vecs[3].yi = '{1000, 0, -1000, 0, 1000, 0, -1000, 0};

    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;

    repeat (3) @(posedge clk);
    #1 chk_reset("por");
    #2 rst_n = 1'b1;
    #1 chk("por_ready_before_edge", int'(bus.in_ready), 0);
    @(posedge clk);
    #1 chk("por_ready_after_edge", int'(bus.in_ready), 1);

    for (int v = 0; v < 4; v++) begin
      use_vec(v);
      load(1'b0);
      collect(1'b0, 8);
    end

    for (int f = 0; f < 4; f++) begin
      gen_random();
      load(1'b1);
      collect(1'b1, 8);
    end

    gen_random();
    load(1'b0);
    repeat (4) @(posedge clk);
    pulse_reset("rst_comp");
    use_vec(0);
    load(1'b0);
    collect(1'b0, 8);

    gen_random();
    load(1'b0);
    collect(1'b0, 3);
    chk("unload_n3_re", int'(bus.out_re), exp_r[3]);
    chk("unload_n3_im", int'(bus.out_im), exp_i[3]);
    pulse_reset("rst_unload");
    use_vec(0);
    load(1'b0);
    collect(1'b0, 8);

    for (int f = 0; f < 3; f++) begin
      gen_random();
      load(1'b0);
      fs[f] = first_hs;
      collect(1'b0, 8);
    end
    chk("period_0_1", fs[1] - fs[0], 28);
    chk("period_1_2", fs[2] - fs[1], 28);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
